// File: rtl/rps_match_ctrl.sv
// Rock-paper-scissors match sequencer: collects one move per player per round,
// forfeits missing/invalid moves on timeout, keeps score and declares a match winner.
module rps_match_ctrl #(
  parameter int WINS_NEEDED = 3,
  parameter int MAX_ROUNDS  = 7,
  parameter int TIMEOUT     = 100,
  parameter int CNT_W       = 4,
  parameter int TMR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a_valid,
  input  logic [1:0]       a_move,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [1:0]       b_move,
  output logic             b_ready,
  output logic             round_done,
  output logic [1:0]       round_result,
  output logic [CNT_W-1:0] score_a,
  output logic [CNT_W-1:0] score_b,
  output logic [CNT_W-1:0] round_cnt,
  output logic             match_done,
  output logic [1:0]       match_winner
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_JUDGE, S_DONE} state_t;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WINS_C   = CNT_W'(WINS_NEEDED);
  localparam logic [CNT_W-1:0] ROUNDS_C = CNT_W'(MAX_ROUNDS);

  localparam logic [1:0] MV_ROCK = 2'b11;
  localparam logic [1:0] MV_PAPR = 2'b10;
  localparam logic [1:0] MV_SCIS = 2'b00;
  localparam logic [1:0] MV_BAD  = 2'b01;

  localparam logic [1:0] RES_A   = 2'b01;
  localparam logic [1:0] RES_B   = 2'b10;
  localparam logic [1:0] RES_TIE = 2'b11;

  state_t             state_q, state_d;
  logic               a_got_q, a_got_d, b_got_q, b_got_d;
  logic [1:0]         a_mv_q, a_mv_d, b_mv_q, b_mv_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   score_a_q, score_a_d, score_b_q, score_b_d;
  logic [CNT_W-1:0]   round_cnt_q, round_cnt_d;
  logic [1:0]         round_res_q, round_res_d;
  logic               round_done_q, round_done_d;

  logic               a_fire, b_fire;
  logic               a_fair, b_fair;
  logic [1:0]         judge_res;

  function automatic logic beats(input logic [1:0] x, input logic [1:0] y);
    return (x == MV_ROCK && y == MV_SCIS) ||
           (x == MV_SCIS && y == MV_PAPR) ||
           (x == MV_PAPR && y == MV_ROCK);
  endfunction

  assign a_ready = (state_q == S_COLLECT) && !a_got_q;
  assign b_ready = (state_q == S_COLLECT) && !b_got_q;
  assign a_fire  = a_valid && a_ready;
  assign b_fire  = b_valid && b_ready;

  // An absent move and the reserved encoding are both treated as a forfeit.
  assign a_fair = a_got_q && (a_mv_q != MV_BAD);
  assign b_fair = b_got_q && (b_mv_q != MV_BAD);

  always_comb begin
    judge_res = RES_TIE;
    if (!a_fair && !b_fair)     judge_res = RES_TIE;
    else if (!a_fair)           judge_res = RES_B;
    else if (!b_fair)           judge_res = RES_A;
    else if (a_mv_q == b_mv_q)  judge_res = RES_TIE;
    else if (beats(a_mv_q, b_mv_q)) judge_res = RES_A;
    else                        judge_res = RES_B;
  end

  always_comb begin
    state_d      = state_q;
    a_got_d      = a_got_q;
    b_got_d      = b_got_q;
    a_mv_d       = a_mv_q;
    b_mv_d       = b_mv_q;
    tmr_d        = tmr_q;
    score_a_d    = score_a_q;
    score_b_d    = score_b_q;
    round_cnt_d  = round_cnt_q;
    round_res_d  = round_res_q;
    round_done_d = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_COLLECT;
          score_a_d   = '0;
          score_b_d   = '0;
          round_cnt_d = '0;
          round_res_d = 2'b00;
          tmr_d       = '0;
          a_got_d     = 1'b0;
          b_got_d     = 1'b0;
        end
      end

      S_COLLECT: begin
        if (a_fire) begin
          a_got_d = 1'b1;
          a_mv_d  = a_move;
        end
        if (b_fire) begin
          b_got_d = 1'b1;
          b_mv_d  = b_move;
        end
        tmr_d = tmr_q + TMR_W'(1);
        // A capture on the final timer cycle still counts, so test the _d flags.
        if ((a_got_d && b_got_d) || (tmr_q == TMR_LAST)) begin
          state_d = S_JUDGE;
        end
      end

      S_JUDGE: begin
        round_done_d = 1'b1;
        round_res_d  = judge_res;
        round_cnt_d  = round_cnt_q + CNT_W'(1);
        if (judge_res == RES_A) score_a_d = score_a_q + CNT_W'(1);
        if (judge_res == RES_B) score_b_d = score_b_q + CNT_W'(1);
        tmr_d   = '0;
        a_got_d = 1'b0;
        b_got_d = 1'b0;
        a_mv_d  = 2'b00;
        b_mv_d  = 2'b00;
        if (score_a_d == WINS_C || score_b_d == WINS_C || round_cnt_d == ROUNDS_C) begin
          state_d = S_DONE;
        end else begin
          state_d = S_COLLECT;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_got_q      <= 1'b0;
      b_got_q      <= 1'b0;
      a_mv_q       <= 2'b00;
      b_mv_q       <= 2'b00;
      tmr_q        <= '0;
      score_a_q    <= '0;
      score_b_q    <= '0;
      round_cnt_q  <= '0;
      round_res_q  <= 2'b00;
      round_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_got_q      <= a_got_d;
      b_got_q      <= b_got_d;
      a_mv_q       <= a_mv_d;
      b_mv_q       <= b_mv_d;
      tmr_q        <= tmr_d;
      score_a_q    <= score_a_d;
      score_b_q    <= score_b_d;
      round_cnt_q  <= round_cnt_d;
      round_res_q  <= round_res_d;
      round_done_q <= round_done_d;
    end
  end

  assign round_done   = round_done_q;
  assign round_result = round_res_q;
  assign score_a      = score_a_q;
  assign score_b      = score_b_q;
  assign round_cnt    = round_cnt_q;
  assign match_done   = (state_q == S_DONE);

  always_comb begin
    match_winner = 2'b00;
    if (state_q == S_DONE) begin
      if (score_a_q > score_b_q)      match_winner = RES_A;
      else if (score_b_q > score_a_q) match_winner = RES_B;
      else                            match_winner = RES_TIE;
    end
  end

endmodule
